// File: rtl/pad_cfg_sequencer.sv
// Wishbone master that walks every pad OEN register of the pad configuration
// slave and programs it from a latched mask, with an optional read-check-write-verify mode.
module pad_cfg_sequencer #(
    parameter int          NUM_PADS  = 38,
    parameter logic [31:0] BASE_ADDR = 32'h3000_6000,
    parameter int          TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                start,
    input  logic [NUM_PADS-1:0] mask_i,
    input  logic                verify_i,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [5:0]          err_idx,
    output logic [5:0]          wr_cnt,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [3:0]          wbm_sel_o,
    output logic [31:0]         wbm_adr_o,
    output logic [31:0]         wbm_dat_o,
    input  logic [31:0]         wbm_dat_i,
    input  logic                wbm_ack_i
);

    localparam int         TW       = $clog2(TIMEOUT + 1);
    localparam logic [5:0] LAST_IDX = 6'(NUM_PADS - 1);

    typedef enum logic [2:0] {IDLE, RD, WR, CHK, GAP, FIN} state_t;
    typedef enum logic [1:0] {GAP_ADV, GAP_WR, GAP_CHK} gap_t;

    state_t              state, state_nxt;
    gap_t                gap_to, gap_nxt;
    logic [NUM_PADS-1:0] mask_q;
    logic                verify_q;
    logic [5:0]          idx;
    logic [TW-1:0]       tcnt;

    logic in_bus;
    logic tmo;
    logic pad_bit;
    logic rd_match;
    logic dat_unused;

    assign in_bus     = (state == RD) || (state == WR) || (state == CHK);
    assign tmo        = in_bus && !wbm_ack_i && (tcnt == TW'(TIMEOUT - 1));
    assign pad_bit    = mask_q[idx];
    assign rd_match   = (wbm_dat_i[0] == pad_bit);
    assign dat_unused = ^wbm_dat_i[31:1];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state  <= IDLE;
            gap_to <= GAP_ADV;
        end else begin
            state  <= state_nxt;
            gap_to <= gap_nxt;
        end
    end

    // GAP remembers where to go once the slave has released a registered ack.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_to;
        case (state)
            IDLE: if (start) state_nxt = verify_i ? RD : WR;
            RD: begin
                if (wbm_ack_i) begin
                    state_nxt = GAP;
                    gap_nxt   = rd_match ? GAP_ADV : GAP_WR;
                end else if (tmo) begin
                    state_nxt = FIN;
                end
            end
            WR: begin
                if (wbm_ack_i) begin
                    state_nxt = GAP;
                    gap_nxt   = verify_q ? GAP_CHK : GAP_ADV;
                end else if (tmo) begin
                    state_nxt = FIN;
                end
            end
            CHK: begin
                if (wbm_ack_i) begin
                    state_nxt = rd_match ? GAP : FIN;
                    gap_nxt   = GAP_ADV;
                end else if (tmo) begin
                    state_nxt = FIN;
                end
            end
            GAP: begin
                if (!wbm_ack_i) begin
                    case (gap_to)
                        GAP_WR:  state_nxt = WR;
                        GAP_CHK: state_nxt = CHK;
                        default: state_nxt = (idx == LAST_IDX) ? FIN : (verify_q ? RD : WR);
                    endcase
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mask_q   <= '1;
            verify_q <= 1'b0;
            idx      <= '0;
            tcnt     <= '0;
            err      <= 1'b0;
            err_idx  <= '0;
            wr_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q   <= mask_i;
                        verify_q <= verify_i;
                        idx      <= '0;
                        tcnt     <= '0;
                        err      <= 1'b0;
                        err_idx  <= '0;
                        wr_cnt   <= '0;
                    end
                end
                RD, WR, CHK: begin
                    if (wbm_ack_i) begin
                        tcnt <= '0;
                        if (state == WR) wr_cnt <= wr_cnt + 6'd1;
                        if ((state == CHK) && !rd_match) begin
                            err     <= 1'b1;
                            err_idx <= idx;
                        end
                    end else if (tmo) begin
                        tcnt    <= '0;
                        err     <= 1'b1;
                        err_idx <= idx;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (!wbm_ack_i && (gap_to == GAP_ADV) && (idx != LAST_IDX))
                        idx <= idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decode only from flops, so they stay put for the whole strobe.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        wbm_cyc_o = in_bus;
        wbm_stb_o = in_bus;
        wbm_we_o  = (state == WR);
        wbm_sel_o = in_bus ? 4'hF : 4'h0;
        wbm_adr_o = in_bus ? (BASE_ADDR + {26'b0, idx}) : 32'h0;
        wbm_dat_o = (state == WR) ? {31'b0, pad_bit} : 32'h0;
    end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Scoreboard bench for pad_cfg_sequencer against a registered-ack pad slave
// model with fault injection (ignored write, missing ack, lingering ack).
module tb_pad_cfg_sequencer;

    localparam int          NP   = 38;
    localparam logic [31:0] BASE = 32'h3000_6000;
    localparam logic [NP-1:0] POR_PAT = 38'b11_00000000000000_111111111111111_0_1111_0_1;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xact_t;

    logic          clk;
    logic          resetb;
    logic          start;
    logic [NP-1:0] mask_i;
    logic          verify_i;
    logic          busy, done, err;
    logic [5:0]    err_idx, wr_cnt;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]    wbm_sel_o;
    logic [31:0]   wbm_adr_o, wbm_dat_o, wbm_dat_i;

    int            vectors;
    int            miscompares;
    xact_t         sb[$];
    logic [NP-1:0] model_mem;
    int            exp_wr_cnt;
    logic          exp_err;
    int            exp_err_idx;
    int            no_ack_pad;
    int            ignore_pad;
    int            ack_extra;
    int            stb_run;
    int            last_run;

    logic [NP-1:0] slv_mem;
    logic          slv_ack;
    logic [31:0]   slv_rdat;
    int            slv_hold;
    logic [31:0]   slv_off;

    pad_cfg_sequencer dut (
        .clk(clk), .resetb(resetb), .start(start), .mask_i(mask_i), .verify_i(verify_i),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx), .wr_cnt(wr_cnt),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: ack and read data registered one cycle after strobe, ack held while strobed.
    assign slv_off   = wbm_adr_o - BASE;
    assign wbm_ack_i = slv_ack;
    assign wbm_dat_i = slv_rdat;

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            slv_ack  <= 1'b0;
            slv_rdat <= 32'h0;
            slv_hold <= 0;
            slv_mem  <= POR_PAT;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            slv_ack  <= (int'(slv_off) != no_ack_pad);
            slv_hold <= ack_extra - 1;
            slv_rdat <= {31'b0, slv_mem[slv_off[5:0]]};
            if (wbm_we_o && int'(slv_off) != no_ack_pad && int'(slv_off) != ignore_pad)
                slv_mem[slv_off[5:0]] <= wbm_dat_o[0];
        end else if (slv_hold > 0) begin
            slv_ack  <= 1'b1;
            slv_hold <= slv_hold - 1;
        end else begin
            slv_ack <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Completed transactions (strobe with ack) are popped from the scoreboard.
    always @(negedge clk) begin
        if (resetb && wbm_stb_o && wbm_ack_i) begin
            if (sb.size() == 0) begin
                checkOutput("sb_extra_xact", {32'h0, wbm_adr_o}, 64'h0);
            end else begin
                xact_t x;
                x = sb.pop_front();
                checkOutput("bus_we", {63'b0, wbm_we_o}, {63'b0, x.we});
                checkOutput("bus_adr", {32'b0, wbm_adr_o}, {32'b0, x.adr});
                checkOutput("bus_dat", {32'b0, wbm_dat_o}, {32'b0, x.dat});
                checkOutput("bus_sel_cyc", {59'b0, wbm_sel_o, wbm_cyc_o}, {59'b0, 4'hF, 1'b1});
            end
        end
        if (wbm_stb_o) begin
            stb_run++;
        end else if (stb_run != 0) begin
            last_run = stb_run;
            stb_run  = 0;
        end
    end

    task automatic pushXact(input logic we, input int pad, input logic bitv);
        xact_t x;
        x.we  = we;
        x.adr = BASE + 32'(pad);
        x.dat = {31'b0, bitv};
        sb.push_back(x);
    endtask

    // Predict the bus traffic and outcome of one run, then pulse start.
    task automatic applyStimulus(input logic [NP-1:0] m, input logic v);
        exp_wr_cnt  = 0;
        exp_err     = 1'b0;
        exp_err_idx = 0;
        for (int i = 0; i < NP; i++) begin
            if (i == no_ack_pad) begin
                exp_err     = 1'b1;
                exp_err_idx = i;
                break;
            end
            if (v) begin
                pushXact(1'b0, i, 1'b0);
                if (model_mem[i] == m[i]) continue;
            end
            pushXact(1'b1, i, m[i]);
            exp_wr_cnt++;
            if (i != ignore_pad) model_mem[i] = m[i];
            if (v) begin
                pushXact(1'b0, i, 1'b0);
                if (model_mem[i] != m[i]) begin
                    exp_err     = 1'b1;
                    exp_err_idx = i;
                    break;
                end
            end
        end
        @(negedge clk);
        mask_i   = m;
        verify_i = v;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        mask_i   = ~m;
        verify_i = ~v;
    endtask

    task automatic waitDone(input int limit, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) checkOutput("done_timeout", 64'h0, 64'h1);
    endtask

    task automatic finishRun(input string tag, input int limit, output int cycles);
        waitDone(limit, cycles);
        $display("[TB] %s finished after %0d cycles", tag, cycles);
        checkOutput("run_err", {63'b0, err}, {63'b0, exp_err});
        checkOutput("run_err_idx", {58'b0, err_idx}, 64'(exp_err_idx));
        checkOutput("run_wr_cnt", {58'b0, wr_cnt}, 64'(exp_wr_cnt));
        checkOutput("run_busy_at_done", {63'b0, busy}, 64'h1);
        checkOutput("sb_leftover", 64'(sb.size()), 64'h0);
        @(negedge clk);
        checkOutput("busy_after_done", {62'b0, busy, done}, 64'h0);
    endtask

    task automatic doReset();
        @(negedge clk);
        resetb = 1'b0;
        #1;
        sb.delete();
        model_mem = POR_PAT;
        checkOutput("rst_ctrl", {42'b0, busy, done, err, err_idx, wr_cnt, wbm_cyc_o, wbm_stb_o,
                                 wbm_we_o, wbm_sel_o}, 64'h0);
        checkOutput("rst_bus", {wbm_adr_o, wbm_dat_o}, 64'h0);
        repeat (2) @(negedge clk);
        resetb = 1'b1;
    endtask

    initial begin
        int            cyc;
        logic [63:0]   rnd;
        logic [NP-1:0] m;
        vectors     = 0;
        miscompares = 0;
        resetb      = 1'b0;
        start       = 1'b0;
        mask_i      = '0;
        verify_i    = 1'b0;
        no_ack_pad  = -1;
        ignore_pad  = -1;
        ack_extra   = 0;
        stb_run     = 0;
        last_run    = 0;
        model_mem   = POR_PAT;

        doReset();

        // Plain write of all ones across every pad.
        applyStimulus({NP{1'b1}}, 1'b0);
        finishRun("all_ones", 400, cyc);
        checkOutput("all_ones_in_window", {63'b0, (cyc >= 148 && cyc <= 160)}, 64'h1);

        // Verify mode from power-on contents: only pad 1 differs.
        doReset();
        m    = POR_PAT;
        m[1] = 1'b1;
        applyStimulus(m, 1'b1);
        finishRun("verify_one", 1000, cyc);

        // Slave drops the write to pad 5, the check read must catch it.
        ignore_pad = 5;
        m          = model_mem;
        m[5]       = ~m[5];
        applyStimulus(m, 1'b1);
        finishRun("ignored_write", 1000, cyc);
        ignore_pad = -1;

        // Slave never acks pad 3.
        no_ack_pad = 3;
        rnd = {$urandom(), $urandom()};
        applyStimulus(rnd[NP-1:0], 1'b0);
        finishRun("no_ack", 1000, cyc);
        checkOutput("no_ack_stb_len", 64'(last_run), 64'd16);
        no_ack_pad = -1;

        // Slave keeps ack asserted three cycles past the strobe.
        ack_extra = 3;
        rnd = {$urandom(), $urandom()};
        applyStimulus(rnd[NP-1:0], 1'b0);
        finishRun("late_ack", 2000, cyc);
        rnd = {$urandom(), $urandom()};
        applyStimulus(rnd[NP-1:0], 1'b1);
        finishRun("late_ack_verify", 4000, cyc);
        ack_extra = 0;

        // Restart attempt mid-run is ignored; reset lands at pad 20.
        rnd = {$urandom(), $urandom()};
        applyStimulus(rnd[NP-1:0], 1'b0);
        repeat (10) @(negedge clk);
        mask_i   = ~rnd[NP-1:0];
        verify_i = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc = 0;
        while (!(wbm_stb_o && wbm_adr_o == BASE + 32'd20) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reach_pad20", {63'b0, (wbm_stb_o && wbm_adr_o == BASE + 32'd20)}, 64'h1);
        checkOutput("pad20_wr_cnt", {58'b0, wr_cnt}, 64'd20);
        doReset();
        @(negedge clk);
        checkOutput("post_rst_idle", {62'b0, busy, wbm_stb_o}, 64'h0);

        rnd = {$urandom(), $urandom()};
        applyStimulus(rnd[NP-1:0], 1'b1);
        finishRun("after_reset", 2000, cyc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pad_cfg_sequencer.md
Name: pad_cfg_sequencer

Overview:
- Wishbone master that bulk-programs the per-pad output-enable registers of the pad configuration slave at BASE_ADDR.
- Walks pads 0..NUM_PADS-1. For each pad it issues a single-bit write (optionally read-check-write-verify), so firmware or the boot FSM can apply a full 38-pad direction mask with one start pulse.
- Sits between the housekeeping/boot control logic and the pad configuration Wishbone slave, and shares the clock with that slave.

Parameters:
- NUM_PADS, 38, number of pad OEN registers; pad i is at BASE_ADDR + i (byte offset, addr[7:0] = i).
- BASE_ADDR, 32'h3000_6000, base address of the pad configuration slave.
- TIMEOUT, 16, max cycles strobe may wait for ack before abort.

Ports:
- clk  in  1  clock; also clocks the Wishbone master interface.
- resetb  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to program; ignored while busy.
- mask_i  in  NUM_PADS  target OEN per pad (1=input/disabled driver, 0=output); latched on accepted start.
- verify_i  in  1  1=read-compare mode, latched on accepted start.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at end of sequence (success or error).
- err  out  1  sticky error flag; cleared on next accepted start.
- err_idx  out  6  pad index at which the error occurred.
- wr_cnt  out  6  number of writes issued in the current/last run.
- wbm_cyc_o, wbm_stb_o  out  1  bus cycle/strobe, always driven equal.
- wbm_we_o  out  1  1=write.
- wbm_sel_o  out  4  constant 4'hF while strobing, 0 otherwise.
- wbm_adr_o  out  32  BASE_ADDR + idx.
- wbm_dat_o  out  32  {31'b0, mask[idx]} on writes, 0 otherwise.
- wbm_dat_i  in  32  read data; only bit 0 is used.
- wbm_ack_i  in  1  slave ack.

Behaviour:
- Reset values: all outputs 0. State IDLE, idx=0, latched mask=all 1s.
- States: IDLE, RD, WR, CHK, GAP, FIN.
- Accepting start:
  - In IDLE, start=1 latches mask_i and verify_i, clears err/err_idx/wr_cnt, sets idx=0, and asserts busy from the next cycle.
  - If verify=0, the next state is WR; otherwise RD.
- Bus transaction states (RD/WR/CHK):
  - cyc/stb/adr/we/dat are registered and held stable until wbm_ack_i is sampled 1.
  - At that edge the strobe drops and the FSM enters GAP.
  - A timeout counter increments each cycle stb is held without ack. At TIMEOUT it drops stb, sets err, sets err_idx=idx, and goes to FIN.
- RD ack:
  - If wbm_dat_i[0]==mask[idx], the pad is skipped (no write) and the FSM goes to GAP with advance.
  - Otherwise it goes to GAP, then WR.
- WR ack: wr_cnt increments. If verify=1 the FSM goes via GAP to CHK; otherwise GAP with advance.
- CHK ack:
  - Mismatch sets err, sets err_idx=idx, and goes to FIN (no further pads).
  - Match goes to GAP with advance.
- GAP:
  - The FSM waits until wbm_ack_i is sampled 0. The slave ack is registered and holds while strobed, so this prevents a stale ack from completing the next transaction.
  - On advance: if idx==NUM_PADS-1 go to FIN, else idx++.
- Timing against the 1-cycle registered-ack slave: 4 cycles per transaction. The verify=0 full run is 4*NUM_PADS cycles plus 2.
- FIN: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Concurrent activity:
  - start while busy has no effect.
  - mask_i/verify_i changes mid-run have no effect.
- resetb low mid-run: immediate return to reset values, including stb=0. No partial-write recovery is required, since the slave resets its own registers on the same reset.
- idx is 6 bits and never exceeds NUM_PADS-1. Addresses beyond BASE_ADDR+NUM_PADS-1 are never issued.

Test Plan:
- verify=0, mask=38'h3F_FFFF_FFFF, 1-cycle registered-ack slave model -> 38 writes to 0x3000_6000..0x3000_6025 with dat=1; wr_cnt=38; done within 160 cycles; err=0.
- verify=1, slave preloaded with the power-on pattern (pads 1, 6, 22-35 = 0, others 1), mask = power-on pattern except pad 1 = 1 -> exactly 1 write (addr 0x3000_6001, dat=1) followed by its CHK read; wr_cnt=1; err=0.
- verify=1, slave forced to ignore the write to pad 5 -> CHK mismatch; err=1, err_idx=5; done pulses; no bus access to pad 6.
- Slave never acks pad 3 -> stb held exactly TIMEOUT=16 cycles, then dropped; err=1, err_idx=3; busy falls after the done pulse.
- Slave ack held high an extra 3 cycles after stb drops -> next strobe is not issued until ack is low; no pad skipped or double-counted.
- start pulsed during a run, then resetb asserted at pad 20 -> second start ignored; after reset all outputs are 0 and state is IDLE; a new start runs cleanly from pad 0.
